// File: rtl/fetch_unit.sv
// fetch_unit: PC register, instruction-memory handshake and next-PC resolution for the single-cycle MIPS core
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
);
    typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;
    state_t state, state_next;
    logic [31:0] next_pc;
    logic retire;

    assign imem_addr = pc_out;
    assign pc_plus4  = pc_out + 32'd4;
    assign opcode    = instr[31:26];
    assign retire    = (state == ISSUE) && !stall;

    // State register; reset always lands in FETCH
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    // Next state: leave FETCH on ack, leave ISSUE when downstream releases the instruction
    always_comb begin
        state_next = state;
        if (state == FETCH) state_next = imem_ack ? ISSUE : FETCH;
        else                state_next = stall ? ISSUE : FETCH;
    end

    // Outputs: request is suppressed while rst is held so it reads 0 as a reset value
    always_comb begin
        imem_req    = (state == FETCH) && !rst;
        instr_valid = (state == ISSUE);
    end

    // Redirect target: jump beats branch, which only fires when the ALU reports equality
    always_comb begin
        next_pc = jump ? {pc_plus4[31:28], jump_index, 2'b00}
                : (branch && zero) ? pc_plus4 + {branch_offset[29:0], 2'b00}
                : pc_plus4;
    end

    // PC advances only at retire; instr captures memory data only on an ack in FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out <= RESET_PC;
            instr  <= 32'h0;
        end else begin
            if (retire) pc_out <= next_pc;
            if (state == FETCH && imem_ack) instr <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch sequencing, redirects, stalls, wait states and reset
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch(branch), .zero(zero), .jump(jump), .branch_offset(branch_offset),
        .jump_index(jump_index), .instr(instr), .opcode(opcode),
        .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus4(pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0; branch_offset = 32'h0; jump_index = 26'h0;
        step();
        step();
        check("rst_pc", pc_out, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        check("rst_instr", instr, 32'h0);
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        rst = 1'b0;
        #1;
        check("first_req", 32'(imem_req), 32'h1);

        // zero-wait sequential fetch
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", imem_addr, 32'(4 * i));
            check("seq_req", 32'(imem_req), 32'h1);
            check("seq_valid_f", 32'(instr_valid), 32'h0);
            imem_rdata = 32'h2000_0000 + 32'(i);
            step();
            check("seq_valid_i", 32'(instr_valid), 32'h1);
            check("seq_instr", instr, 32'h2000_0000 + 32'(i));
            check("seq_pc", pc_out, 32'(4 * i));
            check("seq_pc4", pc_plus4, 32'(4 * i + 4));
            check("seq_req_i", 32'(imem_req), 32'h0);
            step();
        end

        // j to 0x40 from pc 0x10
        check("j_pre", pc_out, 32'h10);
        imem_rdata = 32'h0800_0010;
        step();
        check("j_opcode", 32'(opcode), 32'h2);
        jump = 1'b1; jump_index = 26'h10;
        step();
        jump = 1'b0;
        check("j_target", imem_addr, 32'h40);

        // beq taken backwards
        imem_rdata = 32'h1000_FFFE;
        step();
        check("beq_opcode", 32'(opcode), 32'h4);
        branch = 1'b1; zero = 1'b1; branch_offset = 32'hFFFF_FFFE;
        step();
        branch = 1'b0; zero = 1'b0;
        check("beq_taken", imem_addr, 32'h3C);
        step();
        step();
        check("back_to_40", imem_addr, 32'h40);

        // beq not taken
        step();
        branch = 1'b1; zero = 1'b0; branch_offset = 32'hFFFF_FFFE;
        step();
        check("beq_not_taken", imem_addr, 32'h44);

        // large branch to 0x1000_0010
        step();
        branch = 1'b1; zero = 1'b1; branch_offset = 32'h03FF_FFF2;
        step();
        branch = 1'b0; zero = 1'b0;
        check("far_branch", pc_out, 32'h1000_0010);

        // jal with don't-care branch/zero
        imem_rdata = 32'h0C00_0100;
        step();
        check("jal_opcode", 32'(opcode), 32'h3);
        check("jal_link", pc_plus4, 32'h1000_0014);
        jump = 1'b1; jump_index = 26'h000_0100; branch = 1'bx; zero = 1'bx; branch_offset = 32'hx;
        step();
        jump = 1'b0; branch = 1'b0; zero = 1'b0; branch_offset = 32'h0;
        check("jal_target", imem_addr, 32'h1000_0400);

        // stall for 5 cycles with churning redirect inputs
        stall = 1'b1;
        imem_rdata = 32'hAAAA_5555;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            branch = i[0]; zero = 1'b1; jump = (i == 2); jump_index = 26'h3FF_FFFF;
            branch_offset = 32'h100; imem_rdata = 32'h0BAD_0000 + 32'(i);
            step();
            check("stall_valid", 32'(instr_valid), 32'h1);
            check("stall_instr", instr, 32'hAAAA_5555);
            check("stall_pc", pc_out, 32'h1000_0400);
            check("stall_req", 32'(imem_req), 32'h0);
        end
        stall = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        step();
        check("stall_retire", imem_addr, 32'h1000_0404);

        // delayed ack plus spurious ack during ISSUE
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_addr", imem_addr, 32'h1000_0404);
            check("wait_req", 32'(imem_req), 32'h1);
            check("wait_valid", 32'(instr_valid), 32'h0);
        end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        stall = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        check("spur_instr", instr, 32'h1234_5678);
        check("spur_valid", 32'(instr_valid), 32'h1);
        imem_ack = 1'b0; stall = 1'b0;
        step();
        check("spur_next", pc_out, 32'h1000_0408);
        check("spur_held", instr, 32'h1234_5678);

        // reset in FETCH with simultaneous ack
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        step();
        check("rstf_pc", pc_out, 32'h0);
        check("rstf_instr", instr, 32'h0);
        check("rstf_valid", 32'(instr_valid), 32'h0);
        check("rstf_req", 32'(imem_req), 32'h0);
        rst = 1'b0;
        #1;
        check("rstf_restart", 32'(imem_req), 32'h1);
        imem_rdata = 32'h2222_2222;
        step();
        check("rsti_pre", 32'(instr_valid), 32'h1);

        // reset in ISSUE while stalled
        stall = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        check("rsti_pc", pc_out, 32'h0);
        check("rsti_instr", instr, 32'h0);
        check("rsti_valid", 32'(instr_valid), 32'h0);
        #1;
        check("rsti_addr", imem_addr, 32'h0);

        // wrap: branch from 0 to 0xFFFF_FFFC, then sequential to 0
        imem_ack = 1'b1; imem_rdata = 32'h1000_FFFE;
        step();
        branch = 1'b1; zero = 1'b1; branch_offset = 32'hFFFF_FFFE;
        step();
        branch = 1'b0; zero = 1'b0;
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4, 32'h0);
        step();
        step();
        check("wrap_next", pc_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
